// File: rtl/button_event_decoder.sv
// button_event_decoder
//   Turns a clean, debounced button level into single-cycle event strobes:
//   press, release, long-press and (optionally) auto-repeat, plus a `held`
//   level.
//
//   Optional feature macro: BUTTON_EVENT_DECODER_REPEAT_EN
//     defined   -> auto-repeat counter and strobe are built
//     undefined -> repeat_evt is tied to 0 and the repeat counter is removed.
//                  LONG stays until release.
//
//   `release` and `repeat` are reserved words in SystemVerilog. Those two
//   strobes are therefore named release_evt and repeat_evt.
module button_event_decoder #(
  parameter int LONG_CYCLES   = 1000,  // >= 2, counts the press sample
  parameter int REPEAT_CYCLES = 250    // >= 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic press,
  output logic release_evt,
  output logic long_press,
  output logic repeat_evt,
  output logic held
);

  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  state_t        state;
  logic          in_q;
  logic [HW-1:0] hold_cnt;
  logic          rise;
  logic          fall;

  // Edge qualification against the previous sample.
  assign rise = in & ~in_q;
  assign fall = ~in & in_q;

`ifdef BUTTON_EVENT_DECODER_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  localparam logic [RW-1:0] REP_ONE  = RW'(1);

  logic [RW-1:0] rep_cnt;
  logic          rep_q;

  assign repeat_evt = rep_q;
`else
  assign repeat_evt = 1'b0;
`endif

  // Event FSM: strobes default low each cycle; held tracks PRESSED/LONG.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_q        <= 1'b0;
      hold_cnt    <= '0;
      press       <= 1'b0;
      release_evt <= 1'b0;
      long_press  <= 1'b0;
      held        <= 1'b0;
`ifdef BUTTON_EVENT_DECODER_REPEAT_EN
      rep_cnt     <= '0;
      rep_q       <= 1'b0;
`endif
    end else begin
      in_q        <= in;
      press       <= 1'b0;
      release_evt <= 1'b0;
      long_press  <= 1'b0;
`ifdef BUTTON_EVENT_DECODER_REPEAT_EN
      rep_q       <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (rise) begin
            state    <= PRESSED;
            press    <= 1'b1;
            held     <= 1'b1;
            hold_cnt <= HOLD_ONE;
          end
        end

        PRESSED: begin
          // A fall on the completing sample wins: release only.
          if (fall) begin
            state       <= IDLE;
            release_evt <= 1'b1;
            held        <= 1'b0;
          end else if (in) begin
            if (hold_cnt == HOLD_LAST) begin
              state      <= LONG;
              long_press <= 1'b1;
              hold_cnt   <= HOLD_MAX;
`ifdef BUTTON_EVENT_DECODER_REPEAT_EN
              rep_cnt    <= '0;
`endif
            end else if (hold_cnt != HOLD_MAX) begin
              hold_cnt <= hold_cnt + HOLD_ONE;
            end
          end
        end

        LONG: begin
          // A fall on a period-completing sample also yields release only.
          if (fall) begin
            state       <= IDLE;
            release_evt <= 1'b1;
            held        <= 1'b0;
          end else if (in) begin
`ifdef BUTTON_EVENT_DECODER_REPEAT_EN
            if (rep_cnt == REP_LAST) begin
              rep_q   <= 1'b1;
              rep_cnt <= '0;
            end else begin
              rep_cnt <= rep_cnt + REP_ONE;
            end
`endif
          end
        end

        default: begin
          state <= IDLE;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Testbench for button_event_decoder (LONG_CYCLES=8, REPEAT_CYCLES=3).
// Reference model works on the length of the current run of high samples.
module tb_button_event_decoder;

  localparam int L = 8;
  localparam int R = 3;
`ifdef BUTTON_EVENT_DECODER_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic in;
  logic press, release_evt, long_press, repeat_evt, held;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // model state
  int   run_len = 0;
  logic prev    = 1'b0;

  button_event_decoder #(.LONG_CYCLES(L), .REPEAT_CYCLES(R)) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in),
    .press      (press),
    .release_evt(release_evt),
    .long_press (long_press),
    .repeat_evt (repeat_evt),
    .held       (held)
  );

  always #5 clk = ~clk;

  // Drive one sample, advance one clock, return model expectation and DUT
  // outputs as {press, release, long_press, repeat, held}.
  task automatic tick(input logic v, input logic r,
                      output logic [4:0] exp, output logic [4:0] act);
    logic ep, er, el, ek, eh;
    in  = v;
    rst = r;
    @(posedge clk);
    if (r) begin
      run_len = 0;
      prev    = 1'b0;
      exp     = 5'b0;
    end else begin
      ep      = v & ~prev;
      er      = ~v & prev;
      run_len = v ? run_len + 1 : 0;
      el      = v && (run_len == L);
      ek      = REP_EN && v && (run_len > L) && (((run_len - L) % R) == 0);
      eh      = v;
      prev    = v;
      exp     = {ep, er, el, ek, eh};
    end
    @(negedge clk);
    act = {press, release_evt, long_press, repeat_evt, held};
    cyc++;
  endtask

  task automatic test_reset();
    logic [4:0] e, a;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, e, a);
      checks++;
      if (a !== 5'b0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got=%b want=00000", i, a);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, e, a);
      checks++;
      if (a !== e || a !== 5'b0) begin
        failures++;
        $display("FAIL reset_after cyc=%0d got=%b want=00000", i, a);
      end
    end
  endtask

  task automatic test_short_press();
    logic [4:0] e, a;
    int n_press = 0, n_rel = 0, n_long = 0, n_held = 0, t_p = -1, t_r = -1;
    for (int i = 0; i < 8; i++) begin
      tick(i < 4, 1'b0, e, a);
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL short_model i=%0d got=%b want=%b", i, a, e);
      end
      if (a[4]) begin n_press++; t_p = i; end
      if (a[3]) begin n_rel++;   t_r = i; end
      if (a[2]) n_long++;
      if (a[0]) n_held++;
    end
    checks++;
    if (n_press != 1 || n_rel != 1 || n_long != 0 || n_held != 4 || t_p != 0 || t_r != 4) begin
      failures++;
      $display("FAIL short_summary press=%0d@%0d rel=%0d@%0d long=%0d held=%0d want 1@0 1@4 0 4",
               n_press, t_p, n_rel, t_r, n_long, n_held);
    end
  endtask

  task automatic test_long_repeat();
    logic [4:0] e, a;
    int t_long = -1, t_rel = -1, n_rep = 0;
    int rep_t[$];
    for (int i = 0; i < 24; i++) begin
      tick(i < 20, 1'b0, e, a);
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL long_model i=%0d got=%b want=%b", i, a, e);
      end
      if (a[2]) t_long = i;
      if (a[1]) rep_t.push_back(i);
      if (a[3]) t_rel = i;
    end
    n_rep = rep_t.size();
    checks++;
    if (t_long != 7 || t_rel != 20) begin
      failures++;
      $display("FAIL long_timing long@%0d rel@%0d want long@7 rel@20", t_long, t_rel);
    end
    checks++;
    if (REP_EN) begin
      if (n_rep != 4 || rep_t[0] != 10 || rep_t[1] != 13 || rep_t[2] != 16 || rep_t[3] != 19) begin
        failures++;
        $display("FAIL repeat_times count=%0d want 4 at 10,13,16,19", n_rep);
      end
    end else if (n_rep != 0) begin
      failures++;
      $display("FAIL repeat_disabled count=%0d want 0", n_rep);
    end
  endtask

  task automatic test_boundary();
    logic [4:0] e, a;
    int t_long, t_rel;
    for (int len = 7; len <= 8; len++) begin
      t_long = -1; t_rel = -1;
      for (int i = 0; i < len + 3; i++) begin
        tick(i < len, 1'b0, e, a);
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL boundary_model len=%0d i=%0d got=%b want=%b", len, i, a, e);
        end
        if (a[2]) t_long = i;
        if (a[3]) t_rel = i;
      end
      checks++;
      if (len == 7 && (t_long != -1 || t_rel != 7)) begin
        failures++;
        $display("FAIL boundary7 long@%0d rel@%0d want none rel@7", t_long, t_rel);
      end else if (len == 8 && (t_long != 7 || t_rel != 8)) begin
        failures++;
        $display("FAIL boundary8 long@%0d rel@%0d want long@7 rel@8", t_long, t_rel);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [4:0] e, a;
    int n_rel = 0;
    for (int i = 0; i < 14; i++) begin
      // reset at ticks 9 and 10 with the button still held
      tick(1'b1, (i == 9 || i == 10), e, a);
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL midrst_model i=%0d got=%b want=%b", i, a, e);
      end
      if (a[3]) n_rel++;
      if (i == 9 || i == 10) begin
        checks++;
        if (a !== 5'b0) begin
          failures++;
          $display("FAIL midrst_clear i=%0d got=%b want=00000", i, a);
        end
      end
      if (i == 11) begin
        checks++;
        if (a[4] !== 1'b1 || a[0] !== 1'b1) begin
          failures++;
          $display("FAIL midrst_repress got=%b want press=1 held=1", a);
        end
      end
    end
    checks++;
    if (n_rel != 0) begin
      failures++;
      $display("FAIL midrst_no_release count=%0d want 0", n_rel);
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, e, a);
  endtask

  task automatic test_random();
    logic [4:0] e, a;
    logic lvl = 1'b0;
    int   len;
    for (int k = 0; k < 300; k++) begin
      lvl = ~lvl;
      len = lvl ? $urandom_range(1, 16) : $urandom_range(1, 4);
      for (int i = 0; i < len; i++) begin
        tick(lvl, ($urandom_range(0, 99) < 2), e, a);
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL random k=%0d i=%0d got=%b want=%b", k, i, a, e);
        end
        checks++;
        if ($countones(a[4:1]) > 1) begin
          failures++;
          $display("FAIL onehot_strobes got=%b want at most one", a[4:1]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in  = 1'b0;
    @(negedge clk);
    test_reset();
    test_short_press();
    test_long_repeat();
    test_boundary();
    test_reset_mid_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Consumes the clean, debounced button level produced by the input debouncer and turns it into single-cycle event strobes for the game/control logic: press, release, long-press and (optionally) auto-repeat. The debouncer handles the pin side of the button interface; this block handles the logic side. It sits between the debouncer output and any FSM that needs edge-qualified button events instead of a raw level.

## Interface

- `LONG_CYCLES`, default 1000: consecutive high samples, counting the press sample, required to declare a long press; legal range ≥ 2.
- `REPEAT_CYCLES`, default 250: period in clk cycles of auto-repeat strobes after a long press; legal range ≥ 1.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in`  input  1  debounced button level, synchronous to `clk`; 1 = pressed.
- `press`  output  1  one-cycle strobe on a press.
- `release`  output  1  one-cycle strobe on a release.
- `long_press`  output  1  one-cycle strobe when the hold reaches `LONG_CYCLES`.
- `repeat`  output  1  one-cycle strobe every `REPEAT_CYCLES` while a long hold continues.
- `held`  output  1  level; 1 while the decoder is in PRESSED or LONG.

## Operation

- Registered edge detect: `in_q` holds the previous sample of `in`. Rising edge = `in & ~in_q`; falling edge = `~in & in_q`.
- All outputs are registered. Reset value of every output, `in_q`, and both counters is 0; state is IDLE.
- FSM states:
  - IDLE: on a rising edge, go to PRESSED, pulse `press`, and clear `hold_cnt` to 1.
  - PRESSED: while `in`=1, increment `hold_cnt`. When `hold_cnt` would reach `LONG_CYCLES`, go to LONG, pulse `long_press`, and clear `rep_cnt`. On a falling edge, go to IDLE and pulse `release`.
  - LONG: while `in`=1, increment `rep_cnt`. When it reaches `REPEAT_CYCLES`, pulse `repeat` and reset `rep_cnt` to 0. On a falling edge, go to IDLE and pulse `release`.
- `hold_cnt` width is `$clog2(LONG_CYCLES+1)`. It saturates and never wraps.
- `rep_cnt` width is `$clog2(REPEAT_CYCLES+1)`. It wraps to 0 only via the repeat reload.
- Simultaneous events:
  - A falling edge on the same sample that would complete `LONG_CYCLES`: `release` only, no `long_press`.
  - A falling edge on the same sample that would complete a repeat period: `release` only, no `repeat`.
- At most one of `press`/`release`/`long_press`/`repeat` is high in any cycle.
- `in` high when reset deasserts: treated as a fresh rising edge, so `press` fires.
- Reset mid-hold: all state is cleared. No `release` is emitted for the aborted hold.

## Timing

- Latency is 1 cycle from the sampling edge to the strobe. If `in` is first sampled 1 at edge k, `press` is high during cycle k+1.
- `long_press` goes high `LONG_CYCLES`−1 cycles after `press` goes high, provided `in` stays 1.
- The first `repeat` is `REPEAT_CYCLES` cycles after `long_press`. Subsequent `repeat` strobes are `REPEAT_CYCLES` apart.
- `release` is high the cycle after `in` is first sampled 0. `held` drops in the same cycle `release` rises.
- `held` rises in the same cycle as `press`.
- A minimal 1-cycle-high `in` produces `press` then `release` on consecutive cycles.

## Configuration

- `BUTTON_EVENT_DECODER_REPEAT_EN`
  - Defined: auto-repeat logic and `rep_cnt` are built as described.
  - Undefined: `repeat` is tied to 0 and `rep_cnt` is removed. LONG remains until release, emitting no strobes.
  - `press`, `release`, `long_press` and `held` behave identically either way.

## Test plan

All scenarios use `LONG_CYCLES`=8 and `REPEAT_CYCLES`=3.

- Reset held 3 cycles with `in`=0 -> all outputs 0 throughout and after; no strobes.
- `in` high for 4 cycles then low -> `press` at cycle 1 after the rise; `release` 4 cycles later; no `long_press`; `held` high for exactly 4 cycles.
- `in` high for 20 cycles with macro defined -> `press` at t, `long_press` at t+7, `repeat` at t+10, t+13, t+16, t+19; then `release` after the fall.
- `in` high for exactly 7 samples -> `release` fires; `long_press` never fires. Repeat with 8 samples -> `long_press` then `release` on the next cycle.
- `rst` asserted mid-hold at t+9 with `in` still 1, then released -> outputs cleared with no `release`; `press` refires 1 cycle after reset deasserts.
- Macro undefined, `in` high for 20 cycles -> `long_press` at t+7; `repeat` stays 0; `release` still fires after the fall.
